axis_circular_trigger: RTL and testbench
========================================

AXIS_CIRCULAR_TRIGGER -- requirements
Module: axis_circular_trigger

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, AXIS data width in bits.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, width of the signed sample in tdata[SAMPLE_WIDTH-1:0]; SAMPLE_WIDTH <= AXIS_TDATA_WIDTH.
REQ-003 SHALL have parameter CNTR_WIDTH, default 32, holdoff counter width.
REQ-004 aclk  input  1  single clock; all logic on rising edge.
REQ-005 areset  input  1  reset, asynchronous, active-high.
REQ-006 cfg_arm  input  1  level; rising edge arms, low disarms.
REQ-007 cfg_source  input  1  0 = internal level crossing, 1 = external trigger.
REQ-008 cfg_slope  input  1  0 = rising crossing, 1 = falling crossing.
REQ-009 cfg_level  input  SAMPLE_WIDTH  signed threshold.
REQ-010 cfg_holdoff  input  CNTR_WIDTH  beats to pass after arming before a trigger is accepted (pre-trigger fill).
REQ-011 ext_trigger  input  1  asynchronous external trigger, rising edge active.
REQ-012 trigger  output  1  sticky trigger to the downstream circular packetizer.
REQ-013 sts_state  output  2  current FSM state encoding.
REQ-014 s_axis_tready  output  1 / s_axis_tdata  input  AXIS_TDATA_WIDTH / s_axis_tvalid  input  1  slave stream.
REQ-015 m_axis_tready  input  1 / m_axis_tdata  output  AXIS_TDATA_WIDTH / m_axis_tvalid  output  1  master stream.

Function
REQ-016 Stream SHALL be combinational pass-through: m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready, in every state; block never stalls the stream.
REQ-017 A beat SHALL be defined as a cycle with s_axis_tvalid & m_axis_tready; only beats advance counters or evaluate crossings.
REQ-018 FSM states SHALL be IDLE=0, HOLDOFF=1, ARMED=2, TRIGGERED=3, reported on sts_state.
REQ-019 cfg_arm SHALL be registered once; arm event = registered low and current high.
REQ-020 IDLE -> HOLDOFF on arm event; holdoff counter cleared, prev-sample-valid flag cleared.
REQ-021 HOLDOFF: counter increments by 1 per beat; transition to ARMED on the beat at which counter+1 >= cfg_holdoff; cfg_holdoff = 0 transitions to ARMED the cycle after entry without waiting for a beat.
REQ-022 Each beat in HOLDOFF or ARMED SHALL store the signed sample as prev and set prev-valid.
REQ-023 Internal crossing (cfg_source=0), evaluated only in ARMED on a beat with prev-valid set: rising = prev < cfg_level and sample >= cfg_level; falling = prev > cfg_level and sample <= cfg_level; comparisons signed at SAMPLE_WIDTH.
REQ-024 External (cfg_source=1): ext_trigger SHALL pass a 2-flop synchronizer plus edge-detect flop; a detected rising edge while ARMED sets a pending flag; ARMED -> TRIGGERED on the next beat with pending set; edges outside ARMED are discarded and pending cleared on leaving ARMED.
REQ-025 ARMED -> TRIGGERED on the qualifying beat; trigger registered, high the cycle after that beat, so the qualifying beat itself is seen by downstream with trigger low.
REQ-026 trigger SHALL stay high while in TRIGGERED; no re-evaluation of crossings in TRIGGERED.
REQ-027 cfg_arm low (registered) SHALL force IDLE from any state, clearing trigger, counter, prev-valid and pending on the next edge; takes priority over any simultaneous transition.
REQ-028 A new arm event requires cfg_arm low for at least one cycle; holding cfg_arm high never re-arms.
REQ-029 Counter SHALL saturate at all-ones, never wrap.
REQ-030 cfg_* inputs SHALL be quasi-static; changes while not IDLE give defined but unspecified crossing results.

Reset
REQ-031 areset high SHALL immediately set state IDLE, trigger 0, sts_state 0, counter 0, prev 0, prev-valid 0, pending 0, synchronizer and cfg_arm flops 0.
REQ-032 After areset release, block SHALL wait in IDLE for an arm event even if cfg_arm is already high (registered cfg_arm starts 0, so a held-high cfg_arm arms on the first cycle).
REQ-033 Stream pass-through SHALL remain combinationally active during reset.

Verification
REQ-034 cfg_holdoff=4, rising, level=100, samples 0,10,20,30,40,50,150 continuous valid -> ARMED after 4th beat, trigger high one cycle after the beat carrying 150.
REQ-035 Falling, level=-50, samples 0,-60 during HOLDOFF then -70,-40,-60 in ARMED -> trigger after beat -60 only (crossing inside holdoff ignored).
REQ-036 cfg_source=1, ext_trigger pulse during HOLDOFF then another in ARMED with tvalid low 5 cycles -> first ignored; trigger rises one cycle after first beat following the second pulse.
REQ-037 TRIGGERED, then cfg_arm low for 1 cycle and high again -> trigger 0, IDLE then HOLDOFF, counter 0.
REQ-038 areset asserted mid-HOLDOFF with m_axis_tready toggling -> outputs 0 asynchronously; m_axis_tvalid keeps following s_axis_tvalid throughout.

Source files
------------

// File: rtl/axis_circular_trigger_if.sv
// AXI-Stream handshake bundle (data, valid, ready) with master/slave views.
interface axis_circular_trigger_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_circular_trigger.sv
// Trigger generator for a circular stream packetizer: watches a pass-through AXIS stream
// and raises a sticky trigger on a signed level crossing or a synchronized external edge.
module axis_circular_trigger #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned SAMPLE_WIDTH     = 16,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                           aclk,
    input  logic                           areset,

    input  logic                           cfg_arm,
    input  logic                           cfg_source,
    input  logic                           cfg_slope,
    input  logic signed [SAMPLE_WIDTH-1:0] cfg_level,
    input  logic        [CNTR_WIDTH-1:0]   cfg_holdoff,

    input  logic                           ext_trigger,
    output logic                           trigger,
    output logic        [1:0]              sts_state,

    axis_circular_trigger_if.slave         s_axis,
    axis_circular_trigger_if.master        m_axis
);

    localparam int unsigned CNT_EXT_W = CNTR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLDOFF   = 2'd1,
        ST_ARMED     = 2'd2,
        ST_TRIGGERED = 2'd3
    } state_t;

    state_t                          state;
    logic        [CNTR_WIDTH-1:0]    holdoff_cnt;
    logic signed [SAMPLE_WIDTH-1:0]  prev_sample;
    logic                            prev_valid;
    logic                            ext_pending;

    logic                            arm_q;
    logic                            ext_meta;
    logic                            ext_sync;
    logic                            ext_prev;

    logic [AXIS_TDATA_WIDTH-1:0]     s_tdata;
    logic signed [SAMPLE_WIDTH-1:0]  sample;
    logic                            beat;
    logic                            arm_event;
    logic                            ext_rise;
    logic [CNT_EXT_W-1:0]            cnt_plus1;
    logic                            holdoff_done;
    logic                            rise_cross;
    logic                            fall_cross;
    logic                            hit;

    // Stream is a pure wire path, live in every state and during reset.
    assign s_tdata       = s_axis.tdata;
    assign m_axis.tdata  = s_tdata;
    assign m_axis.tvalid = s_axis.tvalid;
    assign s_axis.tready = m_axis.tready;

    assign beat      = s_axis.tvalid & m_axis.tready;
    assign sample    = s_tdata[SAMPLE_WIDTH-1:0];
    assign arm_event = cfg_arm & ~arm_q;
    assign ext_rise  = ext_sync & ~ext_prev;

    assign cnt_plus1    = {1'b0, holdoff_cnt} + CNT_EXT_W'(1);
    assign holdoff_done = cnt_plus1 >= {1'b0, cfg_holdoff};

    assign rise_cross = (prev_sample <  cfg_level) && (sample >= cfg_level);
    assign fall_cross = (prev_sample >  cfg_level) && (sample <= cfg_level);
    assign hit        = cfg_source ? ext_pending
                                   : (prev_valid && (cfg_slope ? fall_cross : rise_cross));

    assign sts_state = state;

    // Arm edge register and external trigger synchronizer with edge-detect stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arm_q    <= 1'b0;
            ext_meta <= 1'b0;
            ext_sync <= 1'b0;
            ext_prev <= 1'b0;
        end else begin
            arm_q    <= cfg_arm;
            ext_meta <= ext_trigger;
            ext_sync <= ext_meta;
            ext_prev <= ext_sync;
        end
    end

    // Trigger FSM; dropping cfg_arm overrides every other transition.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= ST_IDLE;
            trigger     <= 1'b0;
            holdoff_cnt <= '0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
            ext_pending <= 1'b0;
        end else if (!cfg_arm) begin
            state       <= ST_IDLE;
            trigger     <= 1'b0;
            holdoff_cnt <= '0;
            prev_valid  <= 1'b0;
            ext_pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    trigger <= 1'b0;
                    if (arm_event) begin
                        state       <= ST_HOLDOFF;
                        holdoff_cnt <= '0;
                        prev_valid  <= 1'b0;
                        ext_pending <= 1'b0;
                    end
                end

                ST_HOLDOFF: begin
                    if (beat) begin
                        prev_sample <= sample;
                        prev_valid  <= 1'b1;
                        if (holdoff_cnt != '1) begin
                            holdoff_cnt <= holdoff_cnt + CNTR_WIDTH'(1);
                        end
                    end
                    if ((cfg_holdoff == '0) || (beat && holdoff_done)) begin
                        state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (ext_rise) begin
                        ext_pending <= 1'b1;
                    end
                    if (beat) begin
                        prev_sample <= sample;
                        prev_valid  <= 1'b1;
                        if (hit) begin
                            state       <= ST_TRIGGERED;
                            trigger     <= 1'b1;
                            ext_pending <= 1'b0;
                        end
                    end
                end

                ST_TRIGGERED: begin
                    trigger <= 1'b1;
                end

                default: begin
                    state   <= ST_IDLE;
                    trigger <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_circular_trigger.sv
// Bench for axis_circular_trigger: beat-level scoreboard of pass-through data,
// trigger and state, plus direct checks around arming, disarming and reset.
module tb_axis_circular_trigger;

    logic        aclk;
    logic        areset;
    logic        cfg_arm;
    logic        cfg_source;
    logic        cfg_slope;
    logic signed [15:0] cfg_level;
    logic [31:0] cfg_holdoff;
    logic        ext_trigger;
    logic        trigger;
    logic [1:0]  sts_state;

    axis_circular_trigger_if #(.DATA_WIDTH(32)) s_if ();
    axis_circular_trigger_if #(.DATA_WIDTH(32)) m_if ();

    axis_circular_trigger #(
        .AXIS_TDATA_WIDTH (32),
        .SAMPLE_WIDTH     (16),
        .CNTR_WIDTH       (32)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cfg_arm     (cfg_arm),
        .cfg_source  (cfg_source),
        .cfg_slope   (cfg_slope),
        .cfg_level   (cfg_level),
        .cfg_holdoff (cfg_holdoff),
        .ext_trigger (ext_trigger),
        .trigger     (trigger),
        .sts_state   (sts_state),
        .s_axis      (s_if),
        .m_axis      (m_if)
    );

    typedef struct {
        logic [31:0] data;
        logic        trig;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of valid data with ready high; expected post-beat trigger/state queued.
    task automatic send_beat(input int smp, input logic exp_trig, input logic [1:0] exp_st);
        exp_t e;
        s_if.tdata  = 32'(smp);
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        e.data = 32'(smp);
        e.trig = exp_trig;
        e.st   = exp_st;
        sb.push_back(e);
        @(posedge aclk); #2;
        s_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk); #2;
        end
    endtask

    task automatic disarm();
        cfg_arm = 1'b0;
        @(posedge aclk); #2;
        chk("disarm_state", 32'(sts_state), 32'd0);
        chk("disarm_trig", 32'(trigger), 32'd0);
    endtask

    task automatic arm();
        cfg_arm = 1'b1;
        @(posedge aclk); #2;
        chk("arm_state", 32'(sts_state), 32'd1);
    endtask

    // Beat monitor: pass-through data at mid-cycle, trigger/state just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (!areset && s_if.tvalid && m_if.tready) begin
                chk("beat_tvalid", 32'(m_if.tvalid), 32'd1);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("beat_tdata", m_if.tdata, e.data);
                    @(posedge aclk); #1;
                    chk("beat_trigger", 32'(trigger), 32'(e.trig));
                    chk("beat_state", 32'(sts_state), 32'(e.st));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        areset      = 1'b1;
        cfg_arm     = 1'b0;
        cfg_source  = 1'b0;
        cfg_slope   = 1'b0;
        cfg_level   = 16'sd100;
        cfg_holdoff = 32'd4;
        ext_trigger = 1'b0;
        s_if.tdata  = 32'h0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;

        repeat (3) @(posedge aclk);
        #2;
        chk("rst_state", 32'(sts_state), 32'd0);
        chk("rst_trig", 32'(trigger), 32'd0);
        areset = 1'b0;
        idle(2);
        chk("idle_state", 32'(sts_state), 32'd0);

        // Rising crossing of 100 after a 4-beat holdoff.
        arm();
        send_beat(0,   1'b0, 2'd1);
        send_beat(10,  1'b0, 2'd1);
        send_beat(20,  1'b0, 2'd1);
        send_beat(30,  1'b0, 2'd2);
        send_beat(40,  1'b0, 2'd2);
        send_beat(50,  1'b0, 2'd2);
        send_beat(150, 1'b1, 2'd3);
        idle(2);
        chk("sticky_trig", 32'(trigger), 32'd1);
        send_beat(0,   1'b1, 2'd3);
        send_beat(200, 1'b1, 2'd3);

        // Short disarm re-arms with a fresh holdoff count.
        disarm();
        arm();
        chk("rearm_trig", 32'(trigger), 32'd0);
        send_beat(0, 1'b0, 2'd1);
        send_beat(0, 1'b0, 2'd1);
        send_beat(0, 1'b0, 2'd1);
        send_beat(0, 1'b0, 2'd2);
        idle(3);
        chk("hold_arm_no_rearm", 32'(sts_state), 32'd2);

        // Falling crossing of -50; the crossing inside holdoff must not count.
        disarm();
        cfg_slope   = 1'b1;
        cfg_level   = -16'sd50;
        cfg_holdoff = 32'd2;
        arm();
        send_beat(0,   1'b0, 2'd1);
        send_beat(-60, 1'b0, 2'd2);
        send_beat(-70, 1'b0, 2'd2);
        send_beat(-40, 1'b0, 2'd2);
        send_beat(-60, 1'b1, 2'd3);

        // External trigger: edge in holdoff is dropped, edge in armed fires on next beat.
        disarm();
        cfg_source  = 1'b1;
        cfg_slope   = 1'b0;
        cfg_level   = 16'sd100;
        cfg_holdoff = 32'd3;
        arm();
        ext_trigger = 1'b1;
        idle(2);
        ext_trigger = 1'b0;
        idle(4);
        chk("ext_holdoff_state", 32'(sts_state), 32'd1);
        send_beat(0, 1'b0, 2'd1);
        send_beat(0, 1'b0, 2'd1);
        send_beat(0, 1'b0, 2'd2);
        send_beat(5, 1'b0, 2'd2);
        ext_trigger = 1'b1;
        idle(2);
        ext_trigger = 1'b0;
        idle(3);
        chk("ext_wait_state", 32'(sts_state), 32'd2);
        chk("ext_wait_trig", 32'(trigger), 32'd0);
        send_beat(7, 1'b1, 2'd3);

        // Zero holdoff arms without a beat; first armed beat has no previous sample.
        disarm();
        cfg_source  = 1'b0;
        cfg_holdoff = 32'd0;
        arm();
        idle(1);
        chk("zero_holdoff_state", 32'(sts_state), 32'd2);
        send_beat(200, 1'b0, 2'd2);
        send_beat(50,  1'b0, 2'd2);
        s_if.tdata  = 32'd200;
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b0;
        #1;
        chk("stall_tready", 32'(s_if.tready), 32'd0);
        chk("stall_tvalid", 32'(m_if.tvalid), 32'd1);
        chk("stall_tdata", m_if.tdata, 32'd200);
        @(posedge aclk); #2;
        chk("stall_state", 32'(sts_state), 32'd2);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        send_beat(100, 1'b1, 2'd3);

        // Async reset mid-holdoff with the stream toggling underneath.
        disarm();
        cfg_holdoff = 32'd10;
        arm();
        send_beat(1, 1'b0, 2'd1);
        send_beat(2, 1'b0, 2'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("async_rst_state", 32'(sts_state), 32'd0);
        chk("async_rst_trig", 32'(trigger), 32'd0);
        for (int i = 0; i < 6; i++) begin
            m_if.tready = i[0];
            s_if.tvalid = i[1];
            s_if.tdata  = 32'(i * 3 + 1);
            #1;
            chk("rst_pass_tready", 32'(s_if.tready), 32'(i[0]));
            chk("rst_pass_tvalid", 32'(m_if.tvalid), 32'(i[1]));
            chk("rst_pass_tdata", m_if.tdata, 32'(i * 3 + 1));
            @(posedge aclk); #2;
        end
        chk("rst_hold_state", 32'(sts_state), 32'd0);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        areset = 1'b0;
        @(posedge aclk); #2;
        chk("post_rst_arm", 32'(sts_state), 32'd1);
        idle(2);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
